regfile_write_scheduler: RTL and testbench

- Owns the single write port of the dual-read-port register-file RAM (DATA_WIDTH x (MEM_SIZE+1) entries).
- After reset, sequences a zero-clear of every entry, because the RAM itself has no reset.
- Then arbitrates two write requesters (0: ALU writeback, 1: load/external path) onto the port using valid/ready handshakes and round-robin priority.
- Sits between the datapath writeback logic and the RAM's iWriteEnable/iWriteAddress/iDataIn inputs.

---
 rtl/regfile_write_scheduler.sv | 142 ++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_scheduler
// Purpose : Clears the register-file RAM after reset, then round-robin
//           arbitrates two write requesters onto its single write port.
// Revision: 1.0
// ============================================================================
module regfile_write_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid0,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [DATA_WIDTH-1:0] iData0,
  output logic                  oReady0,
  input  logic                  iValid1,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oReady1,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic                  oInitDone,
  output logic                  oGrantId,
  output logic                  oAddrError
);

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(MEM_SIZE);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    ptr_q, ptr_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    gid_q, gid_d;
  logic                    err_q, err_d;

  logic                    run;
  logic                    ready0;
  logic                    ready1;
  logic                    xfer0;
  logic                    xfer1;

  // Ready is gated by Reset so nothing handshakes on a reset edge.
  assign run    = (state_q == ST_RUN);
  assign ready0 = Reset & run & iValid0 & (~iValid1 | ~ptr_q);
  assign ready1 = Reset & run & iValid1 & (~iValid0 |  ptr_q);
  assign xfer0  = iValid0 & ready0;
  assign xfer1  = iValid1 & ready1;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = done_q;
    gid_d     = gid_q;
    err_d     = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        we_d      = 1'b1;
        addr_d    = clr_cnt_q;
        data_d    = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == C_LAST_ADDR) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end

      ST_RUN: begin
        if (xfer0) begin
          addr_d = iAddr0;
          data_d = iData0;
          gid_d  = 1'b0;
          ptr_d  = 1'b1;
          we_d   = (iAddr0 <= C_LAST_ADDR);
          err_d  = (iAddr0 >  C_LAST_ADDR);
        end else if (xfer1) begin
          addr_d = iAddr1;
          data_d = iData1;
          gid_d  = 1'b1;
          ptr_d  = 1'b0;
          we_d   = (iAddr1 <= C_LAST_ADDR);
          err_d  = (iAddr1 >  C_LAST_ADDR);
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      ptr_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      gid_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      gid_q     <= gid_d;
      err_q     <= err_d;
    end
  end

  assign oReady0       = ready0;
  assign oReady1       = ready1;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oWriteData    = data_q;
  assign oInitDone     = done_q;
  assign oGrantId      = gid_q;
  assign oAddrError    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_write_scheduler
// Purpose : Directed vector table, corner-case sequences and random traffic
//           compared against a behavioural write-port model.
// Revision: 1.0
// ============================================================================
module tb_regfile_write_scheduler;

  localparam int MEMSZ = 8;

  logic        clk;
  logic        rst_n;
  logic        iV0, iV1;
  logic [7:0]  iA0, iA1;
  logic [31:0] iD0, iD1;
  logic        oR0, oR1, oWe, oDone, oGid, oErr;
  logic [7:0]  oAddr;
  logic [31:0] oData;

  int checks = 0;
  int errors = 0;

  regfile_write_scheduler #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_SIZE(MEMSZ)) dut (
    .Clock(clk), .Reset(rst_n),
    .iValid0(iV0), .iAddr0(iA0), .iData0(iD0), .oReady0(oR0),
    .iValid1(iV1), .iAddr1(iA1), .iData1(iD1), .oReady1(oR1),
    .oWriteEnable(oWe), .oWriteAddress(oAddr), .oWriteData(oData),
    .oInitDone(oDone), .oGrantId(oGid), .oAddrError(oErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM fed by the DUT's write port.
  logic [31:0] ram [0:MEMSZ];
  always @(posedge clk)
    if (oWe === 1'b1 && oAddr <= MEMSZ) ram[oAddr] <= oData;

  // Behavioural model of what the write port should present.
  bit          m_run, m_done, m_we, m_gid, m_err;
  int          m_cnt, m_ptr;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] exp_mem [0:MEMSZ];
  bit          er0, er1, r0_s, r1_s;

  typedef struct {
    bit rst; bit v0; logic [7:0] a0; logic [31:0] d0;
    bit v1; logic [7:0] a1; logic [31:0] d1;
    bit er0; bit er1; bit ewe; logic [7:0] eaddr; logic [31:0] edata;
    bit egid; bit eerr; bit edone;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit v0, logic [7:0] a0, logic [31:0] d0,
                              bit v1, logic [7:0] a1, logic [31:0] d1,
                              bit r0, bit r1, bit we, logic [7:0] addr,
                              logic [31:0] data, bit gid, bit err, bit done);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.er0 = r0; v.er1 = r1; v.ewe = we; v.eaddr = addr; v.edata = data;
    v.egid = gid; v.eerr = err; v.edone = done;
    return v;
  endfunction

  function automatic logic [63:0] pack(logic we, logic [7:0] addr, logic [31:0] data,
                                       logic gid, logic err, logic done);
    return {20'b0, we, addr, data, gid, err, done};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0;
    m_done = 0; m_gid = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit rst, input logic [7:0] a0, input logic [31:0] d0,
                            input logic [7:0] a1, input logic [31:0] d1);
    int k;
    logic [7:0] a;
    if (m_we && m_addr <= MEMSZ) exp_mem[m_addr] = m_data;
    if (!rst) begin
      model_reset();
    end else if (!m_run) begin
      m_we = 1; m_addr = 8'(m_cnt); m_data = '0; m_err = 0;
      if (m_cnt == MEMSZ) begin m_run = 1; m_done = 1; end
      m_cnt++;
    end else begin
      k = er0 ? 0 : (er1 ? 1 : -1);
      if (k < 0) begin
        m_we = 0; m_err = 0;
      end else begin
        a      = (k == 0) ? a0 : a1;
        m_addr = a;
        m_data = (k == 0) ? d0 : d1;
        m_gid  = (k == 1);
        m_ptr  = 1 - k;
        m_we   = (a <= MEMSZ);
        m_err  = (a > MEMSZ);
      end
    end
  endtask

  // Entered just after a rising edge; leaves 1 ns after the next one.
  task automatic cycle(input bit rst, input bit v0, input logic [7:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [7:0] a1, input logic [31:0] d1);
    rst_n = rst; iV0 = v0; iA0 = a0; iD0 = d0; iV1 = v1; iA1 = a1; iD1 = d1;
    @(negedge clk);
    // Whoever has the only request wins; on contention the pointer decides.
    er0 = rst && m_run && v0 && (!v1 || m_ptr == 0);
    er1 = rst && m_run && v1 && (!v0 || m_ptr == 1);
    r0_s = oR0; r1_s = oR1;
    chk("ready", {62'b0, oR0, oR1}, {62'b0, er0, er1});
    model_edge(rst, a0, d0, a1, d1);
    @(posedge clk);
    #1;
    chk("model_write", pack(oWe, oAddr, oData, oGid, oErr, oDone),
        pack(m_we, m_addr, m_data, m_gid, m_err, m_done));
  endtask

  task automatic idle();
    cycle(1, 0, 8'd0, 32'd0, 0, 8'd0, 32'd0);
  endtask

  initial begin
    rst_n = 0; iV0 = 0; iV1 = 0; iA0 = '0; iA1 = '0; iD0 = '0; iD1 = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Directed vectors: reset, sweep, single write, out-of-range write, idle.
    tbl.push_back(mk(0, 0, 8'd0, 32'd0, 0, 8'd0, 32'd0, 0, 0, 0, 8'd0, 32'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'd2, 32'd5, 1, 8'd4, 32'd6, 0, 0, 0, 8'd0, 32'd0, 0, 0, 0));
    for (int i = 0; i <= MEMSZ; i++)
      tbl.push_back(mk(1, i == 0, 8'd5, 32'h77, i == 3, 8'd6, 32'h66, 0, 0,
                       1, 8'(i), 32'd0, 0, 0, i == MEMSZ));
    tbl.push_back(mk(1, 1, 8'd3, 32'hDEADBEEF, 0, 8'd0, 32'd0, 1, 0,
                     1, 8'd3, 32'hDEADBEEF, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 32'd0, 0, 8'd0, 32'd0, 0, 0,
                     0, 8'd3, 32'hDEADBEEF, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 32'd0, 1, 8'd9, 32'h12345678, 0, 1,
                     0, 8'd9, 32'h12345678, 1, 1, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 8'd0, 32'd0, 0, 8'd0, 32'd0, 0, 0,
                       0, 8'd9, 32'h12345678, 1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
      chk($sformatf("vec%0d_ready", i), {62'b0, r0_s, r1_s}, {62'b0, tbl[i].er0, tbl[i].er1});
      chk($sformatf("vec%0d_write", i), pack(oWe, oAddr, oData, oGid, oErr, oDone),
          pack(tbl[i].ewe, tbl[i].eaddr, tbl[i].edata, tbl[i].egid, tbl[i].eerr, tbl[i].edone));
      if (i == 12) chk("ram3_after_write", {32'b0, ram[3]}, 64'hDEADBEEF);
    end
    for (int k = 0; k <= MEMSZ; k++)
      chk($sformatf("ram%0d_after_bad_addr", k), {32'b0, ram[k]},
          {32'b0, (k == 3) ? 32'hDEADBEEF : 32'h0});

    // Reset pulsed mid-sweep: sweep restarts and init-done waits for the full pass.
    cycle(0, 0, 8'd0, 32'd0, 0, 8'd0, 32'd0);
    for (int i = 0; i <= 4; i++) begin
      idle();
      chk("sweep_a_addr", {55'b0, oWe, oAddr}, {55'b0, 1'b1, 8'(i)});
    end
    cycle(0, 0, 8'd0, 32'd0, 0, 8'd0, 32'd0);
    chk("midsweep_reset", pack(oWe, oAddr, oData, oGid, oErr, oDone), 64'd0);
    for (int i = 0; i <= MEMSZ; i++) begin
      idle();
      chk("sweep_b", {54'b0, oWe, oAddr, oDone}, {54'b0, 1'b1, 8'(i), i == MEMSZ});
    end

    // Continuous contention right after reset: grants 0,1,0,1.
    for (int j = 0; j < 4; j++) begin
      cycle(1, 1, 8'd1, 32'(100 + j), 1, 8'd2, 32'(200 + j));
      chk("contend_ready", {62'b0, r0_s, r1_s}, {62'b0, j % 2 == 0, j % 2 == 1});
      chk("contend_grant", {55'b0, oGid, oAddr}, {55'b0, j % 2 == 1, (j % 2 == 0) ? 8'd1 : 8'd2});
    end
    idle();
    chk("contend_ram1", {32'b0, ram[1]}, 64'd102);
    chk("contend_ram2", {32'b0, ram[2]}, 64'd203);

    // Random traffic, including out-of-range addresses and occasional resets.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 99) != 0,
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 10)), $urandom,
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 10)), $urandom);
    end
    for (int n = 0; n < 12; n++) idle();
    for (int k = 0; k <= MEMSZ; k++)
      chk($sformatf("final_ram%0d", k), {32'b0, ram[k]}, {32'b0, exp_mem[k]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
